// File: rtl/noncoh_sum_peak_if.sv
// Interface bundling the coherent-sample input, the read-back of the stored
// non-coherent value, the summed write-back output and the per-block peak
// report of the non-coherent summation stage.
//
// master : source of coherent samples and stored values (drives inputs)
// slave  : the summation stage itself
//
// Signals
//   coh_valid, coh_data{I,Q,exponent}, coh_shift, first_acc,
//   block_start, block_end                     -> sample and its control bits
//   noncoh_data, noncoh_shift, extra_shift     -> stored value, 2 cycles later
//   exceed, out_valid, noncoh_out              <- summed result
//   peak_valid, peak_value, peak_index,
//   exceed_any                                 <- block peak report
interface noncoh_sum_peak_if #(
    parameter int IQ_WIDTH    = 10,
    parameter int SHIFT_WIDTH = 4,
    parameter int NC_WIDTH    = 8,
    parameter int OUT_WIDTH   = 9,
    parameter int IDX_WIDTH   = 10
) ();
    logic                               coh_valid;
    logic [2*IQ_WIDTH+SHIFT_WIDTH-1:0]  coh_data;
    logic [SHIFT_WIDTH-1:0]             coh_shift;
    logic                               first_acc;
    logic                               block_start;
    logic                               block_end;
    logic [NC_WIDTH-1:0]                noncoh_data;
    logic [SHIFT_WIDTH-1:0]             noncoh_shift;
    logic                               extra_shift;
    logic                               exceed;
    logic                               out_valid;
    logic [OUT_WIDTH-1:0]               noncoh_out;
    logic                               peak_valid;
    logic [OUT_WIDTH-1:0]               peak_value;
    logic [IDX_WIDTH-1:0]               peak_index;
    logic                               exceed_any;

    modport master (
        output coh_valid, coh_data, coh_shift, first_acc, block_start, block_end,
        output noncoh_data, noncoh_shift, extra_shift,
        input  exceed, out_valid, noncoh_out,
        input  peak_valid, peak_value, peak_index, exceed_any
    );

    modport slave (
        input  coh_valid, coh_data, coh_shift, first_acc, block_start, block_end,
        input  noncoh_data, noncoh_shift, extra_shift,
        output exceed, out_valid, noncoh_out,
        output peak_valid, peak_value, peak_index, exceed_any
    );
endinterface

// File: rtl/noncoh_sum_peak.sv
// Non-coherent summation stage with built-in block peak tracking.
//
// Each coherent correlation result {I, Q, exponent} is turned into an
// amplitude (max + min/2), aligned by the block-floating shift, added to the
// stored non-coherent value (or used alone on the first round), saturated
// and presented for write-back three cycles after it was accepted. The peak
// amplitude, its 0-based position and a sticky exceed flag are tracked per
// search block and reported with a one-cycle pulse after the block's last
// sample.
//
// Ports
//   clk    system clock
//   rst_b  asynchronous active-low reset
//   bus    noncoh_sum_peak_if slave modport (sample in, sum and peak out)
module noncoh_sum_peak #(
    parameter int IQ_WIDTH    = 10,
    parameter int SHIFT_WIDTH = 4,
    parameter int NC_WIDTH    = 8,
    parameter int OUT_WIDTH   = 9,
    parameter int IDX_WIDTH   = 10
) (
    input  logic             clk,
    input  logic             rst_b,
    noncoh_sum_peak_if.slave bus
);
    localparam int CW = 2*IQ_WIDTH + SHIFT_WIDTH;
    localparam int SW = IQ_WIDTH + 1;
    localparam logic [SW-1:0]        SAT_LIMIT = SW'(1) << OUT_WIDTH;
    localparam logic [OUT_WIDTH-1:0] SAT_VALUE = {{(OUT_WIDTH-1){1'b1}}, 1'b0};

    // Control bits carried alongside each sample: {first_acc, block_start, block_end}
    localparam int C_FIRST = 2;
    localparam int C_START = 1;
    localparam int C_END   = 0;

    // Rounded right shift; the addition is one bit wider so x + 2^(k-1)
    // cannot wrap. For k=0 the rounding term shifts out to zero.
    function automatic logic [IQ_WIDTH-1:0] rshift_round(
        input logic [IQ_WIDTH-1:0]    x,
        input logic [SHIFT_WIDTH-1:0] k
    );
        logic [IQ_WIDTH:0] half_lsb;
        logic [IQ_WIDTH:0] t;
        half_lsb = ((IQ_WIDTH+1)'(1) << k) >> 1;
        t        = {1'b0, x} + half_lsb;
        return IQ_WIDTH'(t >> k);
    endfunction

    // ---------------------------------------------------------------- S0
    logic [IQ_WIDTH-1:0]    comp [2];
    logic [IQ_WIDTH-1:0]    mag_reg [2];
    logic [SHIFT_WIDTH-1:0] exponent;
    logic [SHIFT_WIDTH-1:0] eff_shift_next;
    logic [SHIFT_WIDTH-1:0] eff_shift_s0_reg;
    logic                   s0_valid_reg;
    logic [2:0]             s0_ctrl_reg;

    assign comp[0]  = bus.coh_data[CW-1 -: IQ_WIDTH];
    assign comp[1]  = bus.coh_data[SHIFT_WIDTH +: IQ_WIDTH];
    assign exponent = bus.coh_data[SHIFT_WIDTH-1:0];

    // Magnitude of I and Q; the most negative code maps onto 2^(IQ_WIDTH-1),
    // which still fits the unsigned IQ_WIDTH-bit result.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mag
            logic [IQ_WIDTH-1:0] mag_next;
            logic [IQ_WIDTH-1:0] mag_q_reg;
            assign mag_next = comp[gi][IQ_WIDTH-1] ? (~comp[gi] + IQ_WIDTH'(1)) : comp[gi];
            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) mag_q_reg <= '0;
                else        mag_q_reg <= mag_next;
            end
            assign mag_reg[gi] = mag_q_reg;
        end
    endgenerate

    // A larger exponent than target would call for a left shift; clamp to 0.
    assign eff_shift_next = (bus.coh_shift >= exponent) ? (bus.coh_shift - exponent) : '0;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            s0_valid_reg     <= 1'b0;
            s0_ctrl_reg      <= '0;
            eff_shift_s0_reg <= '0;
        end else begin
            s0_valid_reg     <= bus.coh_valid;
            s0_ctrl_reg      <= {bus.first_acc, bus.block_start, bus.block_end};
            eff_shift_s0_reg <= eff_shift_next;
        end
    end

    // ---------------------------------------------------------------- S1
    logic [IQ_WIDTH-1:0]    amp_next;
    logic [IQ_WIDTH-1:0]    amp_reg;
    logic [SHIFT_WIDTH-1:0] eff_shift_s1_reg;
    logic                   s1_valid_reg;
    logic [2:0]             s1_ctrl_reg;

    always_comb begin
        amp_next = '0;
        if (mag_reg[0] >= mag_reg[1]) amp_next = mag_reg[0] + (mag_reg[1] >> 1);
        else                          amp_next = mag_reg[1] + (mag_reg[0] >> 1);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            amp_reg          <= '0;
            eff_shift_s1_reg <= '0;
            s1_valid_reg     <= 1'b0;
            s1_ctrl_reg      <= '0;
        end else begin
            amp_reg          <= amp_next;
            eff_shift_s1_reg <= eff_shift_s0_reg;
            s1_valid_reg     <= s0_valid_reg;
            s1_ctrl_reg      <= s0_ctrl_reg;
        end
    end

    // ---------------------------------------------------------------- S2
    logic [IQ_WIDTH-1:0]  coh_term;
    logic [IQ_WIDTH-1:0]  nc_term;
    logic [SW-1:0]        sum_next;
    logic [SW-1:0]        adj_next;
    logic [OUT_WIDTH-1:0] result_next;
    logic                 exceed_next;

    always_comb begin
        coh_term = rshift_round(amp_reg, eff_shift_s1_reg);
        nc_term  = '0;
        if (!s1_ctrl_reg[C_FIRST])
            nc_term = rshift_round(IQ_WIDTH'(bus.noncoh_data), bus.noncoh_shift);
        sum_next = {1'b0, coh_term} + {1'b0, nc_term};
        adj_next = bus.extra_shift ? ((sum_next >> 1) + SW'(sum_next[0])) : sum_next;
        // Saturation is decided on the un-halved sum.
        if (sum_next >= SAT_LIMIT) result_next = SAT_VALUE;
        else                       result_next = OUT_WIDTH'(adj_next);
        exceed_next = s1_valid_reg & result_next[OUT_WIDTH-1];
    end

    logic                 out_valid_reg;
    logic [OUT_WIDTH-1:0] noncoh_out_reg;
    logic                 exceed_reg;
    logic                 s2_start_reg;
    logic                 s2_end_reg;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid_reg  <= 1'b0;
            noncoh_out_reg <= '0;
            exceed_reg     <= 1'b0;
            s2_start_reg   <= 1'b0;
            s2_end_reg     <= 1'b0;
        end else begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                noncoh_out_reg <= result_next;
                exceed_reg     <= exceed_next;
                s2_start_reg   <= s1_ctrl_reg[C_START];
                s2_end_reg     <= s1_ctrl_reg[C_END];
            end
        end
    end

    // ------------------------------------------------------- peak tracker
    // Works from the registered output, so the report lands the cycle after
    // the block's last out_valid.
    logic [IDX_WIDTH-1:0] idx_cnt_reg;
    logic [IDX_WIDTH-1:0] idx_inc;
    logic [OUT_WIDTH-1:0] peak_value_reg;
    logic [IDX_WIDTH-1:0] peak_index_reg;
    logic                 exceed_any_reg;
    logic                 peak_valid_reg;

    assign idx_inc = idx_cnt_reg + IDX_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            idx_cnt_reg    <= '0;
            peak_value_reg <= '0;
            peak_index_reg <= '0;
            exceed_any_reg <= 1'b0;
            peak_valid_reg <= 1'b0;
        end else begin
            peak_valid_reg <= out_valid_reg & s2_end_reg;
            if (out_valid_reg) begin
                if (s2_start_reg) begin
                    idx_cnt_reg    <= '0;
                    peak_value_reg <= noncoh_out_reg;
                    peak_index_reg <= '0;
                    exceed_any_reg <= exceed_reg;
                end else begin
                    idx_cnt_reg    <= idx_inc;
                    // Strict compare: the earliest occurrence keeps a tie.
                    if (noncoh_out_reg > peak_value_reg) begin
                        peak_value_reg <= noncoh_out_reg;
                        peak_index_reg <= idx_inc;
                    end
                    exceed_any_reg <= exceed_any_reg | exceed_reg;
                end
            end
        end
    end

    assign bus.exceed     = exceed_next;
    assign bus.out_valid  = out_valid_reg;
    assign bus.noncoh_out = noncoh_out_reg;
    assign bus.peak_valid = peak_valid_reg;
    assign bus.peak_value = peak_value_reg;
    assign bus.peak_index = peak_index_reg;
    assign bus.exceed_any = exceed_any_reg;
endmodule

// File: tb/tb_noncoh_sum_peak.sv
// Bench for noncoh_sum_peak: a table of directed and random samples is laid
// out one slot per clock, a reference model derives the expected outputs for
// every cycle from plain integer arithmetic, and every cycle is compared.
module tb_noncoh_sum_peak;
    localparam int IQ_W  = 10;
    localparam int SH_W  = 4;
    localparam int NC_W  = 8;
    localparam int OUT_W = 9;
    localparam int IDX_W = 10;
    localparam int NSLOT = 360;
    localparam int NCYC  = NSLOT + 8;

    logic clk   = 1'b0;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    noncoh_sum_peak_if #(.IQ_WIDTH(IQ_W), .SHIFT_WIDTH(SH_W), .NC_WIDTH(NC_W),
                         .OUT_WIDTH(OUT_W), .IDX_WIDTH(IDX_W)) bus_if ();

    noncoh_sum_peak #(.IQ_WIDTH(IQ_W), .SHIFT_WIDTH(SH_W), .NC_WIDTH(NC_W),
                      .OUT_WIDTH(OUT_W), .IDX_WIDTH(IDX_W)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus_if.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // stimulus table, one entry per clock slot
    int s_v[NCYC], s_i[NCYC], s_q[NCYC], s_exp[NCYC], s_cs[NCYC], s_first[NCYC];
    int s_bs[NCYC], s_be[NCYC], s_nc[NCYC], s_ncs[NCYC], s_xs[NCYC];
    // expected outputs per cycle
    int e_ov[NCYC], e_out[NCYC], e_exc[NCYC], e_pv[NCYC], e_pval[NCYC], e_pidx[NCYC], e_ea[NCYC];
    int r_val[NCYC], t_set[NCYC], t_pk[NCYC], t_idx[NCYC], t_ea[NCYC];
    int wr = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic put(input int i, input int q, input int ex, input int cs, input int first,
                       input int bs, input int be, input int nc, input int ncs, input int xs);
        s_v[wr] = 1; s_i[wr] = i; s_q[wr] = q; s_exp[wr] = ex; s_cs[wr] = cs;
        s_first[wr] = first; s_bs[wr] = bs; s_be[wr] = be;
        s_nc[wr] = nc; s_ncs[wr] = ncs; s_xs[wr] = xs;
        wr++;
    endtask

    function automatic int rsr(input int x, input int k);
        return (k == 0) ? x : (x + (1 << (k - 1))) >> k;
    endfunction

    function automatic int rnd_iq();
        if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) != 0) ? -512 : 511;
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    // Reference model: result of one sample from the arithmetic rules.
    function automatic int model_result(input int k);
        int ai, aq, amp, eff, c, n, s, a;
        ai  = (s_i[k] < 0) ? -s_i[k] : s_i[k];
        aq  = (s_q[k] < 0) ? -s_q[k] : s_q[k];
        amp = (ai > aq) ? ai + aq / 2 : aq + ai / 2;
        eff = (s_cs[k] >= s_exp[k]) ? s_cs[k] - s_exp[k] : 0;
        c   = rsr(amp, eff);
        n   = (s_first[k] != 0) ? 0 : rsr(s_nc[k], s_ncs[k]);
        s   = c + n;
        a   = (s_xs[k] != 0) ? (s + 1) / 2 : s;
        return (s >= (1 << OUT_W)) ? (1 << OUT_W) - 2 : a;
    endfunction

    task automatic build_model();
        int cnt, pk, pidx, ea, r, ex, cur_out, cpk, cidx, cea;
        cnt = 0; pk = 0; pidx = 0; ea = 0;
        for (int k = 0; k < NSLOT; k++) begin
            if (s_v[k] != 0) begin
                r  = model_result(k);
                ex = (r >= (1 << (OUT_W - 1))) ? 1 : 0;
                e_exc[k+2] = ex;
                e_ov[k+3]  = 1;
                r_val[k+3] = r;
                if (s_bs[k] != 0) begin
                    cnt = 0; pk = r; pidx = 0; ea = ex;
                end else begin
                    cnt = (cnt + 1) % (1 << IDX_W);
                    if (r > pk) begin pk = r; pidx = cnt; end
                    ea = ea | ex;
                end
                t_set[k+4] = 1; t_pk[k+4] = pk; t_idx[k+4] = pidx; t_ea[k+4] = ea;
                e_pv[k+4]  = s_be[k];
            end
        end
        cur_out = 0; cpk = 0; cidx = 0; cea = 0;
        for (int c = 0; c < NCYC; c++) begin
            if (e_ov[c] != 0) cur_out = r_val[c];
            e_out[c] = cur_out;
            if (t_set[c] != 0) begin cpk = t_pk[c]; cidx = t_idx[c]; cea = t_ea[c]; end
            e_pval[c] = cpk; e_pidx[c] = cidx; e_ea[c] = cea;
        end
    endtask

    task automatic drive(input int t);
        int k;
        bus_if.coh_valid   = 1'b0;
        bus_if.coh_data    = (2*IQ_W+SH_W)'($urandom);
        bus_if.coh_shift   = SH_W'($urandom);
        bus_if.first_acc   = 1'($urandom);
        bus_if.block_start = 1'($urandom);
        bus_if.block_end   = 1'($urandom);
        if (t < NCYC && s_v[t] != 0) begin
            bus_if.coh_valid   = 1'b1;
            bus_if.coh_data    = {IQ_W'(s_i[t]), IQ_W'(s_q[t]), SH_W'(s_exp[t])};
            bus_if.coh_shift   = SH_W'(s_cs[t]);
            bus_if.first_acc   = 1'(s_first[t]);
            bus_if.block_start = 1'(s_bs[t]);
            bus_if.block_end   = 1'(s_be[t]);
        end
        k = t - 2;
        bus_if.noncoh_data  = NC_W'($urandom);
        bus_if.noncoh_shift = SH_W'($urandom);
        bus_if.extra_shift  = 1'($urandom);
        if (k >= 0 && k < NCYC && s_v[k] != 0) begin
            bus_if.noncoh_data  = NC_W'(s_nc[k]);
            bus_if.noncoh_shift = SH_W'(s_ncs[k]);
            bus_if.extra_shift  = 1'(s_xs[k]);
        end
    endtask

    initial begin
        int len;
        for (int c = 0; c < NCYC; c++) begin
            s_v[c] = 0; e_ov[c] = 0; e_exc[c] = 0; e_pv[c] = 0; t_set[c] = 0; r_val[c] = 0;
        end
        // directed samples: single-sample blocks, then the 8-sample peak block
        put(300, -100, 1, 3, 0, 1, 1, 100, 0, 0);   // 188
        put(300, -100, 1, 3, 0, 1, 1, 100, 0, 1);   // 94
        put(300, -100, 1, 3, 1, 1, 1, 100, 0, 0);   // 88
        put(-512, -512, 0, 0, 0, 1, 1, 255, 0, 0);  // saturate 510
        put(200, 50, 5, 2, 1, 1, 1, 77, 3, 0);      // clamped shift: 225
        put(10, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        put(40, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        put(40, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int j = 0; j < 4; j++) put(5, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        put(5, 0, 0, 0, 1, 0, 1, 0, 0, 0);          // slot 12, block end
        wr = 16;
        while (wr < NSLOT - 30) begin
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0) wr++;
                put(rnd_iq(), rnd_iq(), $urandom_range(0, 15), $urandom_range(0, 15),
                    int'($urandom_range(0, 3) == 0), int'(j == 0), int'(j == len - 1),
                    $urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 1));
            end
            if ($urandom_range(0, 1) != 0) wr++;
        end
        build_model();

        // reset state
        drive(-10);
        bus_if.coh_valid = 1'b0;
        #2 rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_out_valid", int'(bus_if.out_valid), 0);
        check_val("rst_noncoh_out", int'(bus_if.noncoh_out), 0);
        check_val("rst_peak_valid", int'(bus_if.peak_valid), 0);
        check_val("rst_peak_value", int'(bus_if.peak_value), 0);
        check_val("rst_exceed_any", int'(bus_if.exceed_any), 0);
        rst_b = 1'b1;

        for (int t = 0; t < NCYC; t++) begin
            @(posedge clk);
            #1;
            drive(t);
            @(negedge clk);
            check_val("out_valid", int'(bus_if.out_valid), e_ov[t]);
            check_val("noncoh_out", int'(bus_if.noncoh_out), e_out[t]);
            check_val("exceed", int'(bus_if.exceed), e_exc[t]);
            check_val("peak_valid", int'(bus_if.peak_valid), e_pv[t]);
            check_val("peak_value", int'(bus_if.peak_value), e_pval[t]);
            check_val("peak_index", int'(bus_if.peak_index), e_pidx[t]);
            check_val("exceed_any", int'(bus_if.exceed_any), e_ea[t]);
            if (e_ov[t] != 0)
                $display("cycle %0d out %0d exceed_any %0d", t, bus_if.noncoh_out, bus_if.exceed_any);
            if (e_pv[t] != 0)
                $display("cycle %0d block peak %0d at %0d", t, bus_if.peak_value, bus_if.peak_index);
            // hand-computed values from the directed samples
            case (t)
                3:  check_val("dir_sum_188", int'(bus_if.noncoh_out), 188);
                4:  check_val("dir_halved_94", int'(bus_if.noncoh_out), 94);
                5:  begin
                        check_val("dir_first_88", int'(bus_if.noncoh_out), 88);
                        check_val("dir_exceed_early", int'(bus_if.exceed), 1);
                    end
                6:  check_val("dir_sat_510", int'(bus_if.noncoh_out), 510);
                7:  begin
                        check_val("dir_clamp_225", int'(bus_if.noncoh_out), 225);
                        check_val("dir_sat_exceed_any", int'(bus_if.exceed_any), 1);
                    end
                16: begin
                        check_val("dir_peak_pulse", int'(bus_if.peak_valid), 1);
                        check_val("dir_peak_40", int'(bus_if.peak_value), 40);
                        check_val("dir_peak_idx_1", int'(bus_if.peak_index), 1);
                    end
                default: ;
            endcase
        end

        // reset mid-pipeline with back-to-back samples in flight
        @(posedge clk); #1;
        s_v[0] = 1; s_i[0] = 400; s_q[0] = 300; s_exp[0] = 0; s_cs[0] = 0;
        s_first[0] = 0; s_bs[0] = 1; s_be[0] = 1;
        drive(0);
        @(posedge clk); #1;
        drive(0);
        @(posedge clk); #1;
        drive(-10);
        #2 rst_b = 1'b0;
        #1;
        check_val("mid_rst_out_valid", int'(bus_if.out_valid), 0);
        check_val("mid_rst_noncoh_out", int'(bus_if.noncoh_out), 0);
        check_val("mid_rst_exceed", int'(bus_if.exceed), 0);
        check_val("mid_rst_peak_valid", int'(bus_if.peak_valid), 0);
        check_val("mid_rst_peak_value", int'(bus_if.peak_value), 0);
        check_val("mid_rst_peak_index", int'(bus_if.peak_index), 0);
        check_val("mid_rst_exceed_any", int'(bus_if.exceed_any), 0);
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            check_val("post_rst_out_valid", int'(bus_if.out_valid), 0);
            check_val("post_rst_exceed", int'(bus_if.exceed), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/noncoh_sum_peak.md
Name: noncoh_sum_peak

Overview:
- Parametrised successor of the acquisition-engine non-coherent summation stage.
- Converts each complex coherent correlation result into an amplitude and aligns it by a block-floating exponent.
- Adds it to the stored non-coherent value (or replaces it on the first round), saturates, and writes it back.
- Also tracks the peak amplitude, its index and a sticky overflow flag per search block, so the peak-search logic no longer rescans memory.

Parameters:
- IQ_WIDTH, 10: width of each signed I/Q component; also the amplitude width.
- SHIFT_WIDTH, 4: width of exponent and shift fields.
- NC_WIDTH, 8: width of the stored non-coherent value read back; must be ≤ IQ_WIDTH.
- OUT_WIDTH, 9: width of the summed output; must be ≤ IQ_WIDTH.
- IDX_WIDTH, 10: width of the peak index counter.

Ports:
- clk  in  1  system clock
- rst_b  in  1  reset, asynchronous, active low
- coh_valid  in  1  coherent sample valid
- coh_data  in  2*IQ_WIDTH+SHIFT_WIDTH  {real, imag, exponent}, MSB first; I/Q signed two's complement
- coh_shift  in  SHIFT_WIDTH  block target shift, sampled with coh_valid
- first_acc  in  1  first non-coherent round, sampled with coh_valid
- block_start  in  1  marks first sample of a block, sampled with coh_valid
- block_end  in  1  marks last sample of a block, sampled with coh_valid
- noncoh_data  in  NC_WIDTH  stored value; valid exactly 2 cycles after its coh_valid
- noncoh_shift  in  SHIFT_WIDTH  shift for noncoh_data, same timing as noncoh_data
- extra_shift  in  1  halve result, same timing as noncoh_data
- exceed  out  1  combinational; asserted one cycle before out_valid when result bit OUT_WIDTH-1 is set
- out_valid  out  1  noncoh_out valid
- noncoh_out  out  OUT_WIDTH  sum to write back
- peak_valid  out  1  one-cycle pulse, block peak outputs valid
- peak_value  out  OUT_WIDTH  largest noncoh_out in block
- peak_index  out  IDX_WIDTH  0-based sample position of the peak
- exceed_any  out  1  sticky: any sample in current block asserted exceed

Behaviour:
- Reset: all registers 0, i.e. out_valid, noncoh_out, peak_valid, peak_value, peak_index, exceed_any all 0; pipeline valids cleared. Any in-flight sample is dropped.
- Pipeline, one sample per cycle, no backpressure; control bits travel with their sample.
  - S0 (coh_valid cycle): latch |I|, |Q| (|−2^(IQ_WIDTH-1)| = 2^(IQ_WIDTH-1)); latch eff_shift = coh_shift − exponent, clamped to 0 if the exponent is larger.
  - S1: amp = max(|I|,|Q|) + (min(|I|,|Q|) >> 1), IQ_WIDTH bits unsigned, registered.
  - S2, combinational then registered:
    - c = rshift_round(amp, eff_shift).
    - n = rshift_round(zero-extended noncoh_data, noncoh_shift), forced to 0 if first_acc.
    - s = c + n, IQ_WIDTH+1 bits.
    - a = extra_shift ? (s >> 1) + s[0] : s.
    - Clip: if s ≥ 2^OUT_WIDTH (pre-halving compare), result = 2^OUT_WIDTH − 2; otherwise result = a[OUT_WIDTH-1:0].
    - exceed = result[OUT_WIDTH-1], driven in S2.
- rshift_round(x,k): x if k=0, else (x + 2^(k-1)) >> k, computed without overflow.
- Latency: out_valid and noncoh_out register on the clock edge 3 cycles after coh_valid; noncoh_out holds between valids.
- Peak tracker, updated on each out_valid:
  - Sample flagged block_start: index counter := 0; peak := result at index 0; exceed_any := exceed.
  - Otherwise: counter increments (wraps at 2^IDX_WIDTH). Peak updates only if result > peak, strictly, so the first occurrence wins ties. exceed_any |= exceed.
  - Sample flagged block_end: peak_valid pulses the cycle after that out_valid, with final peak/index/exceed_any, which hold until the next block_start.
  - block_start and block_end on the same sample form a one-sample block.
- Samples before any block_start: peak tracking continues from current state; out_valid unaffected.

Test Plan:
- I=300, Q=−100, exponent=1, coh_shift=3, noncoh_data=100, noncoh_shift=0, extra_shift=0 -> amp 350, shift 2 -> 88, noncoh_out=188, out_valid 3 cycles after coh_valid, exceed=0.
- Same sample with extra_shift=1 -> 94; with first_acc=1 and extra_shift=0 -> 88 regardless of noncoh_data.
- I=−512, Q=−512, exponent=0, coh_shift=0, noncoh_data=255 -> s=1023, noncoh_out=510, exceed=1 one cycle before out_valid, exceed_any=1.
- Exponent=5, coh_shift=2 -> eff_shift clamped to 0, amp passed unshifted.
- 8-sample block (block_start on 0, block_end on 7), results 10,40,40,5,…,5 -> peak_valid pulse with peak_value=40, peak_index=1.
- Back-to-back samples, then rst_b low mid-pipeline -> all outputs 0 immediately, no out_valid after release until a new coh_valid.
